// File: rtl/tpu_package.sv
// Shared parameters, decoded instruction layout and sequencer state encoding
// for the systolic-array compute path.
package tpu_package;
   localparam int MUL_SIZE   = 32;
   localparam int ADDR_W     = 10;
   localparam int DIM_W      = 8;
   localparam int PIPE_LAT   = 2 * MUL_SIZE;
   localparam int TILE_SHIFT = $clog2(MUL_SIZE);

   typedef struct packed {
      logic [1:0]       mac_op;
      logic [DIM_W-1:0] u_dim;
      logic [DIM_W-1:0] v_dim;
      logic [DIM_W-1:0] iter_dim;
   } decoded_instr_t;

   typedef enum logic [1:0] {IDLE, WAIT_W, STREAM, DRAIN} seq_state_t;

   // Partial tiles are dropped: only whole MUL_SIZE tiles are computed.
   function automatic logic [DIM_W-1:0] tile_count(input logic [DIM_W-1:0] dim);
      return dim >> TILE_SHIFT;
   endfunction
endpackage

// File: rtl/result_tag_delay.sv
// Fixed-depth shift register that carries accumulator tags alongside the data
// travelling through the systolic array.
module result_tag_delay #(
   parameter int DEPTH = 64,
   parameter int W     = 12
) (
   input  logic         clk,
   input  logic         flush,
   input  logic [W-1:0] tag,
   output logic [W-1:0] delayed_tag
);
   logic [W-1:0] stages [DEPTH];

   always_ff @(posedge clk) begin
      if (flush) begin
         for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
      end else begin
         stages[0] <= tag;
         for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
      end
   end

   assign delayed_tag = stages[DEPTH-1];
endmodule

// File: rtl/compute_tile_sequencer.sv
// Walks the u/k weight-tile space of one MAC instruction, streaming V_dim activation
// rows per tile and producing accumulator controls aligned to the array output.
module compute_tile_sequencer
   import tpu_package::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  decoded_instr_t    instruction_i,
   input  logic              iq_empty_i,
   input  logic              compute_weights_rdy_i,
   input  logic              compute_weights_buffered_i,
   input  logic              act_valid_i,
   output logic              act_rd_en_o,
   output logic [ADDR_W-1:0] act_rd_addr_o,
   output logic              next_weight_tile_o,
   output logic              acc_wr_en_o,
   output logic [ADDR_W-1:0] acc_wr_addr_o,
   output logic              acc_accumulate_o,
   output logic              read_instruction_o,
   output logic              busy_o,
   output logic              done_o,
   output seq_state_t        state_o
);
   localparam int DRAIN_W = $clog2(PIPE_LAT + 1);

   seq_state_t        state;
   logic [DIM_W-1:0]  u_tiles, k_tiles, v_dim, row, k_idx, u_idx;
   logic [DIM_W-1:0]  new_u_tiles, new_k_tiles;
   logic [ADDR_W-1:0] act_base, acc_base, tag_addr;
   logic [DRAIN_W-1:0] drain_cnt;
   logic              tag_acc, zero_pend, accept, last_row, last_k, last_u;

   assign new_u_tiles = tile_count(instruction_i.u_dim);
   assign new_k_tiles = tile_count(instruction_i.iter_dim);
   // The popped entry is still visible while read_instruction_o is high.
   assign accept   = !iq_empty_i && instruction_i.mac_op[1] && !read_instruction_o && !zero_pend;
   assign last_row = (row == v_dim - DIM_W'(1));
   assign last_k   = (k_idx == k_tiles - DIM_W'(1));
   assign last_u   = (u_idx == u_tiles - DIM_W'(1));
   assign busy_o   = (state != IDLE);
   assign state_o  = state;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state              <= IDLE;
         u_tiles            <= '0;
         k_tiles            <= '0;
         v_dim              <= '0;
         row                <= '0;
         k_idx              <= '0;
         u_idx              <= '0;
         act_base           <= '0;
         acc_base           <= '0;
         tag_addr           <= '0;
         tag_acc            <= 1'b0;
         zero_pend          <= 1'b0;
         drain_cnt          <= '0;
         act_rd_en_o        <= 1'b0;
         act_rd_addr_o      <= '0;
         next_weight_tile_o <= 1'b0;
         read_instruction_o <= 1'b0;
         done_o             <= 1'b0;
      end else begin
         act_rd_en_o        <= 1'b0;
         act_rd_addr_o      <= '0;
         tag_addr           <= '0;
         tag_acc            <= 1'b0;
         next_weight_tile_o <= 1'b0;
         read_instruction_o <= 1'b0;
         done_o             <= 1'b0;
         case (state)
            IDLE: begin
               if (zero_pend) begin
                  done_o    <= 1'b1;
                  zero_pend <= 1'b0;
               end else if (accept) begin
                  read_instruction_o <= 1'b1;
                  u_tiles  <= new_u_tiles;
                  k_tiles  <= new_k_tiles;
                  v_dim    <= instruction_i.v_dim;
                  row      <= '0;
                  k_idx    <= '0;
                  u_idx    <= '0;
                  act_base <= '0;
                  acc_base <= '0;
                  if (new_u_tiles == '0 || new_k_tiles == '0 || instruction_i.v_dim == '0)
                     zero_pend <= 1'b1;
                  else
                     state <= WAIT_W;
               end
            end
            WAIT_W: begin
               if (compute_weights_rdy_i) begin
                  state <= STREAM;
                  row   <= '0;
               end
            end
            STREAM: begin
               if (act_valid_i) begin
                  act_rd_en_o   <= 1'b1;
                  act_rd_addr_o <= act_base + ADDR_W'(row);
                  tag_addr      <= acc_base + ADDR_W'(row);
                  tag_acc       <= (k_idx != '0);
                  if (!last_row) begin
                     row <= row + DIM_W'(1);
                  end else begin
                     row <= '0;
                     if (last_k && last_u) begin
                        state     <= DRAIN;
                        drain_cnt <= DRAIN_W'(PIPE_LAT);
                     end else begin
                        next_weight_tile_o <= 1'b1;
                        // k is the inner loop; act base follows k, acc base follows u.
                        if (last_k) begin
                           k_idx    <= '0;
                           u_idx    <= u_idx + DIM_W'(1);
                           act_base <= '0;
                           acc_base <= acc_base + ADDR_W'(v_dim);
                        end else begin
                           k_idx    <= k_idx + DIM_W'(1);
                           act_base <= act_base + ADDR_W'(v_dim);
                        end
                        if (!compute_weights_buffered_i) state <= WAIT_W;
                     end
                  end
               end
            end
            DRAIN: begin
               if (drain_cnt == '0) begin
                  done_o <= 1'b1;
                  state  <= IDLE;
               end else begin
                  drain_cnt <= drain_cnt - DRAIN_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   result_tag_delay #(.DEPTH(PIPE_LAT), .W(ADDR_W + 2)) u_tag_delay (
      .clk         (clk_i),
      .flush       (rst_i),
      .tag         ({act_rd_en_o, tag_addr, tag_acc}),
      .delayed_tag ({acc_wr_en_o, acc_wr_addr_o, acc_accumulate_o})
   );
endmodule

// File: tb/tb_compute_tile_sequencer.sv
// Bench for compute_tile_sequencer: instruction queue and weight unit responders,
// an event scoreboard fed by a loop-nest reference model, vector table and random batches.
module tb_compute_tile_sequencer;
   import tpu_package::*;

   logic              clk_i = 1'b0;
   logic              rst_i;
   decoded_instr_t    instruction_i;
   logic              iq_empty_i, compute_weights_rdy_i, compute_weights_buffered_i, act_valid_i;
   logic              act_rd_en_o, next_weight_tile_o, acc_wr_en_o, acc_accumulate_o;
   logic [ADDR_W-1:0] act_rd_addr_o, acc_wr_addr_o;
   logic              read_instruction_o, busy_o, done_o;
   seq_state_t        state_o;

   always #5 clk_i = ~clk_i;

   compute_tile_sequencer dut (
      .clk_i(clk_i), .rst_i(rst_i), .instruction_i(instruction_i), .iq_empty_i(iq_empty_i),
      .compute_weights_rdy_i(compute_weights_rdy_i),
      .compute_weights_buffered_i(compute_weights_buffered_i), .act_valid_i(act_valid_i),
      .act_rd_en_o(act_rd_en_o), .act_rd_addr_o(act_rd_addr_o),
      .next_weight_tile_o(next_weight_tile_o), .acc_wr_en_o(acc_wr_en_o),
      .acc_wr_addr_o(acc_wr_addr_o), .acc_accumulate_o(acc_accumulate_o),
      .read_instruction_o(read_instruction_o), .busy_o(busy_o), .done_o(done_o),
      .state_o(state_o)
   );

   typedef struct { logic [ADDR_W-1:0] addr; bit pulse; } act_exp_t;
   typedef struct { logic [ADDR_W-1:0] addr; bit accum; } acc_exp_t;
   typedef struct {
      int u, v, it, bmode, gap, vmode;
      int exp_reads, exp_pulses, exp_span;
   } vec_t;

   act_exp_t       exp_act_q[$];
   acc_exp_t       exp_acc_q[$];
   int             acc_cyc_q[$];
   bit             pend_q[$];
   decoded_instr_t instr_q[$];
   int             pop_log[$], done_log[$];
   vec_t           vecs[$];

   int  n_checks = 0, n_fail = 0, cyc = 0;
   int  n_reads, n_pulses, n_done, n_acc, first_rd, last_rd, last_acc_cyc, last_pop_cyc;
   int  gap = 0, vmode = 0, bmode = 0, rdy_cnt = 0;
   bit  quiet = 1'b1, prev_valid = 1'b0;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic check_eq(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: event not allowed here (cycle %0d)", name, cyc);
   endtask

   // Reference model: plain u-outer / k-inner / row loop nest with multiplied addresses.
   function automatic void push_model(input decoded_instr_t ins);
      int ut, kt, v;
      act_exp_t a;
      acc_exp_t c;
      ut = int'(ins.u_dim) / MUL_SIZE;
      kt = int'(ins.iter_dim) / MUL_SIZE;
      v  = int'(ins.v_dim);
      if (ut == 0 || kt == 0 || v == 0) begin
         pend_q.push_back(1'b1);
         return;
      end
      pend_q.push_back(1'b0);
      for (int u = 0; u < ut; u++)
         for (int k = 0; k < kt; k++)
            for (int r = 0; r < v; r++) begin
               a.addr  = ADDR_W'((k * v + r) % (1 << ADDR_W));
               a.pulse = (r == v - 1) && !(u == ut - 1 && k == kt - 1);
               c.addr  = ADDR_W'((u * v + r) % (1 << ADDR_W));
               c.accum = (k != 0);
               exp_act_q.push_back(a);
               exp_acc_q.push_back(c);
            end
   endfunction

   // Scoreboard plus instruction-queue and weight-unit responders, all sampled mid-cycle.
   initial begin
      act_exp_t       ae;
      acc_exp_t       ce;
      decoded_instr_t ins;
      bit             z;
      int             ecyc;
      iq_empty_i = 1'b1;
      instruction_i = '0;
      compute_weights_rdy_i = 1'b1;
      forever begin
         @(negedge clk_i);
         if (!quiet && !rst_i) begin
            if (act_rd_en_o) begin
               n_reads++;
               if (first_rd < 0) first_rd = cyc;
               last_rd = cyc;
               check_eq("read_on_valid_cycle", prev_valid, 1);
               acc_cyc_q.push_back(cyc + PIPE_LAT);
               if (exp_act_q.size() == 0) fail("unexpected_read");
               else begin
                  ae = exp_act_q.pop_front();
                  check_eq("act_rd_addr", act_rd_addr_o, ae.addr);
                  check_eq("next_tile_pulse", next_weight_tile_o, ae.pulse);
               end
            end else if (next_weight_tile_o) fail("pulse_without_last_row");
            if (next_weight_tile_o) n_pulses++;
            if (acc_wr_en_o) begin
               n_acc++;
               last_acc_cyc = cyc;
               if (exp_acc_q.size() == 0 || acc_cyc_q.size() == 0) fail("unexpected_acc_write");
               else begin
                  ce = exp_acc_q.pop_front();
                  ecyc = acc_cyc_q.pop_front();
                  check_eq("acc_wr_addr", acc_wr_addr_o, ce.addr);
                  check_eq("acc_accumulate", acc_accumulate_o, ce.accum);
                  check_eq("acc_latency_cycle", cyc, ecyc);
               end
            end
            if (done_o) begin
               n_done++;
               done_log.push_back(cyc);
               if (pend_q.size() == 0) fail("unexpected_done");
               else begin
                  z = pend_q.pop_front();
                  if (z) check_eq("zero_done_after_pop", cyc, last_pop_cyc + 1);
                  else begin
                     check_eq("done_after_last_write", cyc, last_acc_cyc + 1);
                     check_eq("done_results_left", exp_acc_q.size(), 0);
                  end
               end
            end
            if (read_instruction_o) begin
               pop_log.push_back(cyc);
               if (instr_q.size() == 0) fail("unexpected_pop");
               else begin
                  ins = instr_q.pop_front();
                  push_model(ins);
                  last_pop_cyc = cyc;
               end
            end
         end
         prev_valid = act_valid_i;
         iq_empty_i = (instr_q.size() == 0);
         instruction_i = iq_empty_i ? '0 : instr_q[0];
         if (gap == 0) compute_weights_rdy_i = 1'b1;
         else if (next_weight_tile_o && !quiet) begin
            compute_weights_rdy_i = 1'b0;
            rdy_cnt = gap;
         end else if (rdy_cnt > 0) begin
            rdy_cnt--;
            if (rdy_cnt == 0) compute_weights_rdy_i = 1'b1;
         end
      end
   end

   initial begin
      act_valid_i = 1'b0;
      compute_weights_buffered_i = 1'b0;
      forever begin
         @(posedge clk_i);
         #1;
         case (vmode)
            0:       act_valid_i = 1'b1;
            1:       act_valid_i = ~act_valid_i;
            default: act_valid_i = ($urandom_range(0, 3) != 0);
         endcase
         case (bmode)
            0:       compute_weights_buffered_i = 1'b0;
            1:       compute_weights_buffered_i = 1'b1;
            default: compute_weights_buffered_i = 1'($urandom_range(0, 1));
         endcase
      end
   end

   task automatic clear_counts();
      n_reads = 0; n_pulses = 0; n_done = 0; n_acc = 0;
      first_rd = -1; last_rd = -1;
      pop_log.delete(); done_log.delete();
   endtask

   task automatic push_instr(input int u, input int v, input int it);
      decoded_instr_t ins;
      ins.mac_op   = 2'b10 | 2'($urandom_range(0, 1));
      ins.u_dim    = DIM_W'(u);
      ins.v_dim    = DIM_W'(v);
      ins.iter_dim = DIM_W'(it);
      instr_q.push_back(ins);
   endtask

   task automatic wait_done(input int budget, input string name);
      int n = 0;
      do begin
         @(posedge clk_i);
         n++;
      end while (!(instr_q.size() == 0 && pend_q.size() == 0 && exp_acc_q.size() == 0 &&
                   exp_act_q.size() == 0) && n < budget);
      if (n >= budget) fail({name, "_timeout"});
      repeat (2) @(posedge clk_i);
      #1;
   endtask

   task automatic check_reset_outputs(input string name);
      check_eq({name, "_outputs_zero"},
               {act_rd_en_o, act_rd_addr_o, next_weight_tile_o, acc_wr_en_o, acc_wr_addr_o,
                acc_accumulate_o, read_instruction_o, busy_o, done_o}, 0);
      check_eq({name, "_state_idle"}, state_o, IDLE);
   endtask

   initial begin
      string tag;
      int    total, k;
      rst_i = 1'b1;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      check_reset_outputs("reset");
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      quiet = 1'b0;

      // u, v, iter, bmode, gap, vmode, reads, pulses, first-to-last read span (-1 = unchecked)
      vecs.push_back('{32,   4,  32, 0, 0, 0,    4, 0,    3});
      vecs.push_back('{64,   2,  64, 1, 0, 0,    8, 3,    7});
      vecs.push_back('{64,   2,  64, 0, 5, 0,    8, 3,   25});
      vecs.push_back('{32,   4,  32, 0, 0, 1,    4, 0,    6});
      vecs.push_back('{16,   4,  32, 0, 0, 0,    0, 0,   -1});
      vecs.push_back('{32,   0,  32, 0, 0, 0,    0, 0,   -1});
      vecs.push_back('{64,   4,  16, 0, 0, 0,    0, 0,   -1});
      vecs.push_back('{96,   1,  32, 1, 0, 0,    3, 2,    2});
      vecs.push_back('{32,   3,  96, 0, 0, 0,    9, 2,   10});
      vecs.push_back('{63,   2,  33, 0, 0, 0,    2, 0,    1});
      vecs.push_back('{32, 160, 255, 1, 0, 0, 1120, 6, 1119});
      vecs.push_back('{255, 160, 32, 1, 0, 0, 1120, 6, 1119});

      foreach (vecs[i]) begin
         tag = $sformatf("vec%0d", i);
         bmode = vecs[i].bmode; gap = vecs[i].gap; vmode = vecs[i].vmode;
         clear_counts();
         push_instr(vecs[i].u, vecs[i].v, vecs[i].it);
         wait_done(20000, tag);
         check_eq({tag, "_reads"}, n_reads, vecs[i].exp_reads);
         check_eq({tag, "_pulses"}, n_pulses, vecs[i].exp_pulses);
         check_eq({tag, "_done_count"}, n_done, 1);
         if (vecs[i].exp_span >= 0) check_eq({tag, "_span"}, last_rd - first_rd, vecs[i].exp_span);
         @(negedge clk_i);
         check_eq({tag, "_idle_after"}, busy_o, 0);
      end

      // Back-to-back: second pop must follow the first done by one cycle.
      bmode = 0; gap = 0; vmode = 0;
      clear_counts();
      push_instr(32, 2, 32);
      push_instr(32, 1, 64);
      wait_done(5000, "b2b");
      check_eq("b2b_done_count", n_done, 2);
      if (pop_log.size() < 2 || done_log.size() < 1) fail("b2b_missing_events");
      else check_eq("b2b_second_pop", pop_log[1], done_log[0] + 1);

      // Reset in the middle of tile 1.
      bmode = 1; gap = 0; vmode = 0;
      clear_counts();
      push_instr(64, 4, 64);
      k = 0;
      while (n_reads < 6 && k < 1000) begin
         @(posedge clk_i);
         k++;
      end
      if (k >= 1000) fail("midreset_timeout");
      @(posedge clk_i);
      #1;
      quiet = 1'b1;
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      exp_act_q.delete(); exp_acc_q.delete(); acc_cyc_q.delete();
      pend_q.delete(); instr_q.delete();
      @(negedge clk_i);
      check_reset_outputs("midreset");
      clear_counts();
      quiet = 1'b0;
      repeat (PIPE_LAT + 8) @(posedge clk_i);
      check_eq("midreset_no_acc_writes", n_acc, 0);
      check_eq("midreset_no_pulses", n_pulses, 0);
      #1;
      clear_counts();
      push_instr(32, 4, 32);
      wait_done(5000, "after_reset");
      check_eq("after_reset_reads", n_reads, 4);
      check_eq("after_reset_done", n_done, 1);

      // Random batches, some queued back-to-back.
      bmode = 2; vmode = 2;
      clear_counts();
      total = 0;
      for (int b = 0; b < 5; b++) begin
         gap = $urandom_range(0, 3);
         k = $urandom_range(1, 3);
         for (int j = 0; j < k; j++)
            push_instr($urandom_range(0, 130), $urandom_range(0, 12), $urandom_range(0, 130));
         total += k;
         wait_done(40000, "random");
      end
      check_eq("random_done_count", n_done, total);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
